// File: rtl/coeff_loader_pkg.sv
// Shared definitions for the coefficient loader and the double-buffered coefficient store.
package coeff_loader_pkg;

    localparam int unsigned ADDR_W = 9;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StLo,
        StHi,
        StWrite,
        StSwap
    } loader_state_t;

endpackage

// File: rtl/coeff_loader.sv
// Byte-stream coefficient loader: SYNC_BYTE, then STAGE little-endian 16-bit words,
// written to the inactive bank and committed with a single bank-swap pulse.
module coeff_loader
    import coeff_loader_pkg::*;
#(
    parameter int unsigned STAGE     = 256,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_coeff,
    output logic              wr_en,
    output logic              coeff_up,
    output logic              busy,
    output logic              err
);

    localparam int unsigned GAP_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(STAGE - 1);

    loader_state_t     state;
    logic [ADDR_W-1:0] idx;
    logic [GAP_W-1:0]  gap;
    logic [7:0]        lo_byte;
    logic              accept;
    logic              gap_expired;

    assign accept      = rx_valid & rx_ready;
    // Abort on the idle cycle that brings the gap count to TIMEOUT.
    assign gap_expired = (gap == GAP_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            idx      <= '0;
            gap      <= '0;
            lo_byte  <= '0;
            rx_ready <= 1'b0;
            wr_addr  <= '0;
            wr_coeff <= '0;
            wr_en    <= 1'b0;
            coeff_up <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            wr_en    <= 1'b0;
            coeff_up <= 1'b0;
            err      <= 1'b0;
            unique case (state)
                StIdle: begin
                    rx_ready <= 1'b1;
                    gap      <= '0;
                    if (accept && rx_data == SYNC_BYTE) begin
                        state <= StLo;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                StLo, StHi: begin
                    if (accept) begin
                        gap <= '0;
                        if (state == StLo) begin
                            lo_byte <= rx_data;
                            state   <= StHi;
                        end else begin
                            wr_en    <= 1'b1;
                            wr_addr  <= idx;
                            wr_coeff <= {rx_data, lo_byte};
                            rx_ready <= 1'b0;
                            state    <= StWrite;
                        end
                    end else if (gap_expired) begin
                        // Abandon the frame; the active bank is untouched since no swap follows.
                        state <= StIdle;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        gap   <= '0;
                        idx   <= '0;
                    end else begin
                        gap <= gap + GAP_W'(1);
                    end
                end
                StWrite: begin
                    if (idx == LAST_IDX) begin
                        coeff_up <= 1'b1;
                        state    <= StSwap;
                    end else begin
                        idx      <= idx + ADDR_W'(1);
                        gap      <= '0;
                        rx_ready <= 1'b1;
                        state    <= StLo;
                    end
                end
                StSwap: begin
                    rx_ready <= 1'b1;
                    busy     <= 1'b0;
                    idx      <= '0;
                    state    <= StIdle;
                end
                default: begin
                    rx_ready <= 1'b1;
                    busy     <= 1'b0;
                    state    <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coeff_loader.sv
// Directed-vector bench for coeff_loader with STAGE=4 and TIMEOUT=10.
module tb_coeff_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [8:0]  wr_addr;
    logic [15:0] wr_coeff;
    logic        wr_en;
    logic        coeff_up;
    logic        busy;
    logic        err;

    int tests;
    int fails;

    logic [8:0]  wa[$];
    logic [15:0] wd[$];
    int up_cnt, err_cnt, cyc, last_wr_cyc, up_cyc, dbl_wr, overlap;
    logic wr_prev;

    coeff_loader #(
        .STAGE    (4),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT  (10)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .wr_addr (wr_addr),
        .wr_coeff(wr_coeff),
        .wr_en   (wr_en),
        .coeff_up(coeff_up),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive observer sampled on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (wr_en) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_coeff);
            last_wr_cyc = cyc;
        end
        if (wr_en && wr_prev) dbl_wr = dbl_wr + 1;
        if (wr_en && coeff_up) overlap = overlap + 1;
        if (coeff_up) begin
            up_cnt = up_cnt + 1;
            up_cyc = cyc;
        end
        if (err) err_cnt = err_cnt + 1;
        wr_prev = wr_en;
    end

    task automatic clear_logs();
        wa.delete();
        wd.delete();
        up_cnt = 0; err_cnt = 0; last_wr_cyc = -1; up_cyc = -1; dbl_wr = 0; overlap = 0;
    endtask

    // Called at a falling edge; offers one byte and returns at the falling edge after transfer.
    task automatic send_byte(input logic [7:0] b, input bit hold);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 50) begin
            fails++;
            $display("FAIL send_byte: rx_ready stuck at %b, required 1 for byte %h", rx_ready, b);
        end
        @(negedge clk);
        if (!hold) rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f[9], input bit hold);
        for (int i = 0; i < 9; i++) send_byte(f[i], hold);
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_frame(input string name, input logic [15:0] exp_d[4]);
        tests++;
        if (wa.size() !== 4 || up_cnt !== 1 || err_cnt !== 0) begin
            fails++;
            $display("FAIL %s count: writes=%0d coeff_up=%0d err=%0d, required 4/1/0",
                     name, wa.size(), up_cnt, err_cnt);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (wa[i] !== 9'(i) || wd[i] !== exp_d[i]) begin
                    fails++;
                    $display("FAIL %s write%0d: addr=%0d data=%h, required addr=%0d data=%h",
                             name, i, wa[i], wd[i], i, exp_d[i]);
                end
            end
        end
        tests++;
        if (dbl_wr !== 0 || overlap !== 0) begin
            fails++;
            $display("FAIL %s strobes: double_wr=%0d up_with_wr=%0d, required 0/0",
                     name, dbl_wr, overlap);
        end
        tests++;
        if (up_cyc !== last_wr_cyc + 1) begin
            fails++;
            $display("FAIL %s swap_timing: coeff_up cycle=%0d, required %0d",
                     name, up_cyc, last_wr_cyc + 1);
        end
        tests++;
        if (busy !== 1'b0 || rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s idle_after: busy=%b rx_ready=%b, required 0/1", name, busy, rx_ready);
        end
    endtask

    task automatic test_reset();
        tests++;
        if ({rx_ready, wr_en, coeff_up, busy, err, wr_addr, wr_coeff} !== '0) begin
            fails++;
            $display("FAIL reset_state: rdy=%b wr=%b up=%b busy=%b err=%b addr=%h data=%h, required all 0",
                     rx_ready, wr_en, coeff_up, busy, err, wr_addr, wr_coeff);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: rx_ready=%b, required 1", rx_ready);
        end
    endtask

    task automatic test_full_frame();
        logic [7:0]  f[9] = '{8'hA5, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
        logic [15:0] e[4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        clear_logs();
        send_frame(f, 1'b0);
        check_frame("full_frame", e);
        tests++;
        if (wr_addr !== 9'd3 || wr_coeff !== 16'hDEF0) begin
            fails++;
            $display("FAIL hold_outputs: addr=%0d data=%h, required 3/DEF0", wr_addr, wr_coeff);
        end
    endtask

    task automatic test_garbage();
        logic [7:0]  f[9] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        logic [15:0] e[4] = '{16'h2211, 16'h4433, 16'h6655, 16'h8877};
        clear_logs();
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h11, 1'b0);
        tests++;
        if (wa.size() !== 0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL garbage_discard: writes=%0d busy=%b, required 0/1", wa.size(), busy);
        end
        for (int i = 2; i < 9; i++) send_byte(f[i], 1'b0);
        repeat (4) @(negedge clk);
        check_frame("garbage", e);
    endtask

    task automatic test_timeout();
        logic [7:0]  f[9] = '{8'hA5, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
        logic [15:0] e[4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        int seen;
        clear_logs();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h34, 1'b0);
        seen = -1;
        for (int i = 1; i <= 20 && seen < 0; i++) begin
            @(negedge clk);
            if (err) seen = i;
        end
        tests++;
        if (seen !== 10) begin
            fails++;
            $display("FAIL timeout_err: err at idle cycle %0d, required 10", seen);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout_idle: busy=%b, required 0", busy);
        end
        @(negedge clk);
        tests++;
        if (err !== 1'b0 || err_cnt !== 1 || wa.size() !== 0 || up_cnt !== 0) begin
            fails++;
            $display("FAIL timeout_pulse: err=%b err_cnt=%0d writes=%0d coeff_up=%0d, required 0/1/0/0",
                     err, err_cnt, wa.size(), up_cnt);
        end
        clear_logs();
        send_frame(f, 1'b0);
        check_frame("after_timeout", e);
    endtask

    task automatic test_sync_as_data();
        logic [7:0]  f[9] = '{8'hA5, 8'hA5, 8'hA5, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00};
        logic [15:0] e[4] = '{16'hA5A5, 16'h0001, 16'h0002, 16'h0003};
        clear_logs();
        send_frame(f, 1'b0);
        check_frame("sync_as_data", e);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  f[9] = '{8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
        logic [15:0] e[4] = '{16'hBEEF, 16'hDEAD, 16'hF00D, 16'hCAFE};
        clear_logs();
        send_frame(f, 1'b1);
        check_frame("back_to_back", e);
    endtask

    task automatic test_reset_midframe();
        logic [7:0]  f[9] = '{8'hA5, 8'h10, 8'h00, 8'h20, 8'h00, 8'h30, 8'h00, 8'h40, 8'h00};
        logic [15:0] e[4] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
        clear_logs();
        for (int i = 0; i < 7; i++) send_byte(f[i], 1'b0);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({rx_ready, wr_en, coeff_up, busy, err, wr_addr, wr_coeff} !== '0) begin
            fails++;
            $display("FAIL async_reset: rdy=%b wr=%b up=%b busy=%b err=%b addr=%h data=%h, required all 0",
                     rx_ready, wr_en, coeff_up, busy, err, wr_addr, wr_coeff);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (up_cnt !== 0 || err_cnt !== 0 || wa.size() !== 3 || rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_abandon: coeff_up=%0d err=%0d writes=%0d rdy=%b, required 0/0/3/1",
                     up_cnt, err_cnt, wa.size(), rx_ready);
        end
        clear_logs();
        send_frame(f, 1'b0);
        check_frame("after_reset", e);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc = 0;
        wr_prev = 1'b0;
        rst_n = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        clear_logs();
        repeat (3) @(negedge clk);
        test_reset();
        test_full_frame();
        test_garbage();
        test_timeout();
        test_sync_as_data();
        test_back_to_back();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/coeff_loader.md
COEFF_LOADER -- requirements
Module: coeff_loader

Interface
REQ-001 SHALL have parameter STAGE, default 256: coefficients per frame, range 2..256.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-003 SHALL have parameter TIMEOUT, default 65535: maximum idle cycles allowed between bytes inside a frame.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port rx_data, input, 8: byte from the host link (UART/I2C byte receiver).
REQ-007 SHALL have port rx_valid, input, 1: rx_data is valid.
REQ-008 SHALL have port rx_ready, output, 1: loader accepts a byte; a byte transfers on a clk edge where rx_valid and rx_ready are both 1.
REQ-009 SHALL have port wr_addr, output, 9: coefficient index to the double-buffered coefficient store.
REQ-010 SHALL have port wr_coeff, output, 16: coefficient value.
REQ-011 SHALL have port wr_en, output, 1: single-cycle write strobe.
REQ-012 SHALL have port coeff_up, output, 1: single-cycle bank-swap pulse.
REQ-013 SHALL have port busy, output, 1: a frame is in progress (any state other than IDLE).
REQ-014 SHALL have port err, output, 1: single-cycle pulse when a frame is aborted.

Function
REQ-015 SHALL implement the FSM states IDLE, LO, HI, WRITE and SWAP; all outputs SHALL be registered.
REQ-016 IDLE: rx_ready=1; an accepted byte equal to SYNC_BYTE SHALL move the FSM to LO with idx=0; any other byte SHALL be discarded.
REQ-017 LO: rx_ready=1; an accepted byte SHALL be latched as coefficient bits [7:0], and the FSM SHALL move to HI.
REQ-018 HI: rx_ready=1; an accepted byte SHALL be latched as bits [15:8], and the FSM SHALL move to WRITE.
REQ-019 WRITE: the FSM SHALL stay here exactly 1 cycle, with rx_ready=0, wr_en=1, wr_addr=idx and wr_coeff={hi,lo}.
REQ-020 Write latency: wr_en SHALL be high in the cycle immediately after the edge that accepts the HI byte.
REQ-021 On leaving WRITE: if idx==STAGE-1, the FSM SHALL go to SWAP; otherwise idx SHALL increment and the FSM SHALL go to LO.
REQ-022 SWAP: the FSM SHALL stay here 1 cycle, with rx_ready=0 and coeff_up=1, then go to IDLE; coeff_up SHALL never coincide with wr_en.
REQ-023 wr_addr/wr_coeff SHALL hold their last values while wr_en=0; wr_en SHALL never be high for 2 consecutive cycles.
REQ-024 Timeout: in LO or HI, a gap counter SHALL count cycles without an accepted byte; when it reaches TIMEOUT, the FSM SHALL go to IDLE, pulse err for 1 cycle, and issue no coeff_up.
REQ-025 The gap counter SHALL clear on every accepted byte and on entry to LO; it SHALL be held at 0 in IDLE.
REQ-026 A SYNC_BYTE value received in LO or HI SHALL be treated as data, not as a resync.
REQ-027 Coefficients already written by an aborted frame SHALL remain in the inactive bank; the active bank SHALL be unaffected because no swap occurs.
REQ-028 rx_valid SHALL be ignored whenever rx_ready=0; no byte is consumed in WRITE or SWAP.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately force: FSM=IDLE, idx=0, gap counter=0, wr_en=0, coeff_up=0, err=0, busy=0, wr_addr=0, wr_coeff=0, rx_ready=0.
REQ-030 rx_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-031 A reset in mid-frame SHALL abandon the frame with no coeff_up and no err pulse.

Structure
REQ-032 The FSM state encoding, SYNC_BYTE default and the 9-bit address width SHALL reside in a shared package used by both the loader and the coefficient store.
REQ-033 The design SHALL be a single module with no sub-modules; the gap counter SHALL be inline logic.

Verification
REQ-034 Full frame, STAGE=4: A5, then 34 12, 78 56, BC 9A, F0 DE -> wr_en at addr 0..3 with 1234, 5678, 9ABC, DEF0; coeff_up 1 cycle after the last wr_en; busy drops with the return to IDLE.
REQ-035 Leading garbage 00 FF then A5 frame -> garbage bytes discarded, no wr_en before the HI byte of coefficient 0 is accepted.
REQ-036 TIMEOUT=10: A5 34 then stall 10 cycles -> err pulse 1 cycle, FSM IDLE, no wr_en, no coeff_up; a following valid frame loads normally.
REQ-037 Data byte A5 inside a frame (coefficient 0 = A5 A5) -> wr_coeff=A5A5 written at addr 0, with no resync.
REQ-038 rx_valid held continuously at 1 -> rx_ready=0 during WRITE/SWAP and no byte is lost or duplicated; wr_en count equals STAGE.
REQ-039 rst_n pulsed low after coefficient 2 -> outputs reset asynchronously, no coeff_up, no err; the next frame starts at addr 0.
